// File: rtl/hci_ecc_scrub_sched_if.sv
// TCDM-style request/response bundle shared by the host initiator and the memory port
// of the ECC scrub scheduler.
interface hci_ecc_scrub_sched_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic            r_valid;
    logic [DW-1:0]   r_data;
    logic            r_single_err;
    logic            r_multi_err;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_valid, r_data, r_single_err, r_multi_err
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_valid, r_data, r_single_err, r_multi_err
    );
endinterface

// File: rtl/hci_ecc_scrub_sched.sv
// Shares one ECC-protected TCDM port between a host initiator and a background scrubber.
// Optional starvation guard enabled by defining HCI_ECC_SCRUB_STARVE_EN.
module hci_ecc_scrub_sched #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int SCRUB_INTERVAL = 256,
    parameter int CNT_W          = 16,
    parameter int STARVE_LIMIT   = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [AW-1:0]          scrub_start_i,
    input  logic [AW-1:0]          scrub_end_i,
    hci_ecc_scrub_sched_if.slave   hst,
    hci_ecc_scrub_sched_if.master  mem,
    output logic [CNT_W-1:0]       single_cnt_o,
    output logic [CNT_W-1:0]       multi_cnt_o,
    output logic                   scrub_busy_o,
    output logic                   scrub_wrap_o
);
    localparam int            BW   = DW / 8;
    localparam int            WCW  = $clog2(SCRUB_INTERVAL + 1);
    localparam logic [AW-1:0] STEP = AW'(BW);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_RSP  = 3'd3,
        S_WB_REQ  = 3'd4,
        S_ADVANCE = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_addr;
    logic             r_started;
    logic [WCW-1:0]   r_wait_cnt;
    logic [DW-1:0]    r_wb_data;
    logic             r_owner_host;
    logic             r_owner_scrub;
    logic [CNT_W-1:0] r_single_cnt;
    logic [CNT_W-1:0] r_multi_cnt;
    logic             r_busy;
    logic             r_wrap;

    logic w_scrub_pend;
    logic w_force;
    logic w_host_sel;
    logic w_scrub_sel;
    logic w_scrub_gnt;
    logic w_host_gnt;
    logic w_cancel;
    logic w_scrub_rsp;

    assign w_scrub_pend = (r_state == S_RD_REQ) || (r_state == S_WB_REQ);

`ifdef HCI_ECC_SCRUB_STARVE_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    logic [SCW-1:0] r_starve_cnt;
    assign w_force = w_scrub_pend && (r_starve_cnt == SCW'(STARVE_LIMIT));

    // Starvation counter: cycles the pending scrub op lost arbitration to the host.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
        end else if (w_scrub_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_scrub_pend && w_host_sel) begin
            r_starve_cnt <= r_starve_cnt + SCW'(1);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_host_sel  = hst.req && !w_force;
    assign w_scrub_sel = w_scrub_pend && !w_host_sel;
    assign w_scrub_gnt = w_scrub_sel && mem.gnt;
    assign w_host_gnt  = w_host_sel && mem.gnt;
    // A granted host write to the word being repaired makes the write-back stale.
    assign w_cancel    = (r_state == S_WB_REQ) && w_host_gnt && !hst.wen && (hst.add == r_addr);
    assign w_scrub_rsp = mem.r_valid && r_owner_scrub;

    // Port mux: host passes straight through, scrubber only fills idle slots.
    always_comb begin
        mem.req  = 1'b0;
        mem.add  = '0;
        mem.wen  = 1'b1;
        mem.be   = '0;
        mem.data = '0;
        hst.gnt  = 1'b0;
        if (w_host_sel) begin
            mem.req  = 1'b1;
            mem.add  = hst.add;
            mem.wen  = hst.wen;
            mem.be   = hst.be;
            mem.data = hst.data;
            hst.gnt  = mem.gnt;
        end else if (w_scrub_sel) begin
            mem.req  = 1'b1;
            mem.add  = r_addr;
            mem.wen  = (r_state == S_RD_REQ);
            mem.be   = {BW{1'b1}};
            mem.data = (r_state == S_RD_REQ) ? '0 : r_wb_data;
        end else begin
            mem.req  = 1'b0;
        end
    end

    assign hst.r_valid      = mem.r_valid && r_owner_host;
    assign hst.r_data       = r_owner_host ? mem.r_data : '0;
    assign hst.r_single_err = mem.r_single_err && r_owner_host;
    assign hst.r_multi_err  = mem.r_multi_err && r_owner_host;

    // Scrub FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable_i) w_next = S_WAIT;
                else          w_next = S_IDLE;
            end
            S_WAIT: begin
                if (!enable_i)                                 w_next = S_IDLE;
                else if (r_wait_cnt == WCW'(SCRUB_INTERVAL - 1)) w_next = S_RD_REQ;
                else                                           w_next = S_WAIT;
            end
            S_RD_REQ: begin
                if (w_scrub_gnt) w_next = S_RD_RSP;
                else             w_next = S_RD_REQ;
            end
            S_RD_RSP: begin
                if (w_scrub_rsp) begin
                    if (mem.r_multi_err)       w_next = S_ADVANCE;
                    else if (mem.r_single_err) w_next = S_WB_REQ;
                    else                       w_next = S_ADVANCE;
                end else begin
                    w_next = S_RD_RSP;
                end
            end
            S_WB_REQ: begin
                if (w_scrub_gnt || w_cancel) w_next = S_ADVANCE;
                else                         w_next = S_WB_REQ;
            end
            S_ADVANCE: begin
                if (enable_i) w_next = S_WAIT;
                else          w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, address walker, latched write-back data, owners and error counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_started     <= 1'b0;
            r_wait_cnt    <= '0;
            r_wb_data     <= '0;
            r_owner_host  <= 1'b0;
            r_owner_scrub <= 1'b0;
            r_single_cnt  <= '0;
            r_multi_cnt   <= '0;
            r_busy        <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_busy        <= (w_next != S_IDLE);
            r_wrap        <= (r_state == S_ADVANCE) && (r_addr == scrub_end_i);
            r_owner_host  <= w_host_gnt;
            r_owner_scrub <= w_scrub_gnt && (r_state == S_RD_REQ);
            r_wait_cnt    <= (r_state == S_WAIT) ? r_wait_cnt + WCW'(1) : '0;

            if ((r_state == S_IDLE) && enable_i && !r_started) begin
                r_addr    <= scrub_start_i;
                r_started <= 1'b1;
            end else if (r_state == S_ADVANCE) begin
                r_addr <= (r_addr == scrub_end_i) ? scrub_start_i : r_addr + STEP;
            end else begin
                r_addr <= r_addr;
            end

            if ((r_state == S_RD_RSP) && w_scrub_rsp) begin
                r_wb_data <= mem.r_data;
                if (mem.r_multi_err)       r_multi_cnt  <= sat_inc(r_multi_cnt);
                else if (mem.r_single_err) r_single_cnt <= sat_inc(r_single_cnt);
                else                       r_single_cnt <= r_single_cnt;
            end else begin
                r_wb_data <= r_wb_data;
            end
        end
    end

    assign single_cnt_o = r_single_cnt;
    assign multi_cnt_o  = r_multi_cnt;
    assign scrub_busy_o = r_busy;
    assign scrub_wrap_o = r_wrap;
endmodule

// File: tb/tb_hci_ecc_scrub_sched.sv
// Scoreboard bench for hci_ecc_scrub_sched: expected memory transactions and host
// responses are queued by the stimulus and consumed by negedge monitors.
module tb_hci_ecc_scrub_sched;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [31:0] scrub_start_i;
    logic [31:0] scrub_end_i;
    logic [1:0]  single_cnt_o;
    logic [1:0]  multi_cnt_o;
    logic        scrub_busy_o;
    logic        scrub_wrap_o;

    hci_ecc_scrub_sched_if #(.AW(32), .DW(32)) host_bus ();
    hci_ecc_scrub_sched_if #(.AW(32), .DW(32)) mem_bus ();

    hci_ecc_scrub_sched #(
        .AW(32), .DW(32), .SCRUB_INTERVAL(4), .CNT_W(2), .STARVE_LIMIT(64)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
        .scrub_start_i(scrub_start_i), .scrub_end_i(scrub_end_i),
        .hst(host_bus.slave), .mem(mem_bus.master),
        .single_cnt_o(single_cnt_o), .multi_cnt_o(multi_cnt_o),
        .scrub_busy_o(scrub_busy_o), .scrub_wrap_o(scrub_wrap_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } mtx_t;

    mtx_t        exp_q[$];
    logic [31:0] rsp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          wrap_cnt = 0;
    int          free_scrub = 0;
    int          free_wb = 0;
    bit          free_mode = 1'b0;
    logic [3:0]  err_s = 4'b0;
    logic [3:0]  err_m = 4'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h8) ? 32'hDEAD_BEEF : (32'hA500_0000 | a);
    endfunction

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_m(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        mtx_t t;
        t.add = a; t.wen = w; t.be = b; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic wait_drain(input string name);
        int i = 0;
        while (exp_q.size() != 0 && i < 200) begin step(); i++; end
        chk(name, 73'(exp_q.size()), 73'd0);
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while (scrub_busy_o && i < 200) begin step(); i++; end
        chk(name, 73'(scrub_busy_o), 73'd0);
    endtask

    // Memory model: always grants, answers one cycle later with table data and error flags.
    assign mem_bus.gnt = 1'b1;
    always @(posedge clk) begin
        mem_bus.r_valid      <= mem_bus.req && mem_bus.gnt;
        mem_bus.r_data       <= mem_bus.wen ? mem_data(mem_bus.add) : 32'h0;
        mem_bus.r_single_err <= mem_bus.req && mem_bus.wen && (mem_bus.add < 32'h10) && err_s[mem_bus.add[3:2]];
        mem_bus.r_multi_err  <= mem_bus.req && mem_bus.wen && (mem_bus.add < 32'h10) && err_m[mem_bus.add[3:2]];
    end

    // Monitors: compare every granted memory transaction and every host response.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (scrub_wrap_o) wrap_cnt++;
            if (mem_bus.req && mem_bus.gnt) begin
                if (free_mode) begin
                    if (mem_bus.add != 32'h200) free_scrub++;
                    if (!mem_bus.wen) free_wb++;
                end else if (exp_q.size() == 0) begin
                    chk("mem_unexpected", {mem_bus.add, mem_bus.wen, mem_bus.be, mem_bus.data}, 73'd0);
                end else begin
                    mtx_t e;
                    e = exp_q.pop_front();
                    chk("mem_txn", {mem_bus.add, mem_bus.wen, mem_bus.be, mem_bus.data}, e);
                end
            end
            if (host_bus.r_valid && !free_mode) begin
                if (rsp_q.size() == 0) chk("host_rsp_unexpected", 73'(host_bus.r_data), 73'h1_0000_0000);
                else chk("host_rsp", 73'(host_bus.r_data), 73'(rsp_q.pop_front()));
            end
        end
    end

    initial begin
        int i;
        int snap;
        rst_i = 1'b1; enable_i = 1'b0;
        scrub_start_i = 32'h0; scrub_end_i = 32'hC;
        host_bus.req = 1'b0; host_bus.add = 32'h0; host_bus.wen = 1'b1;
        host_bus.be = 4'h0; host_bus.data = 32'h0;
        repeat (3) step();
        chk("rst_state", {scrub_busy_o, scrub_wrap_o, single_cnt_o, multi_cnt_o, mem_bus.req, host_bus.gnt}, 73'd0);
        rst_i = 1'b0;

        // Clean walk of the window including wrap back to the start.
        push_m(32'h0, 1'b1, 4'hF, 32'h0); push_m(32'h4, 1'b1, 4'hF, 32'h0);
        push_m(32'h8, 1'b1, 4'hF, 32'h0); push_m(32'hC, 1'b1, 4'hF, 32'h0);
        push_m(32'h0, 1'b1, 4'hF, 32'h0);
        enable_i = 1'b1;
        wait_drain("walk_drain");
        enable_i = 1'b0;
        wait_idle("walk_idle");
        chk("walk_wrap", 73'(wrap_cnt), 73'd1);

        // Corrected error at 0x8 is written back with the corrected word.
        err_s = 4'b0100;
        push_m(32'h4, 1'b1, 4'hF, 32'h0); push_m(32'h8, 1'b1, 4'hF, 32'h0);
        push_m(32'h8, 1'b0, 4'hF, 32'hDEAD_BEEF);
        enable_i = 1'b1;
        wait_drain("wb_drain");
        enable_i = 1'b0;
        wait_idle("wb_idle");
        chk("wb_single_cnt", 73'(single_cnt_o), 73'd1);

        // Uncorrectable at 0xC, both flags at 0x4: counted as multi, never written back.
        err_s = 4'b0010; err_m = 4'b1010;
        push_m(32'hC, 1'b1, 4'hF, 32'h0); push_m(32'h0, 1'b1, 4'hF, 32'h0);
        push_m(32'h4, 1'b1, 4'hF, 32'h0); push_m(32'h8, 1'b1, 4'hF, 32'h0);
        enable_i = 1'b1;
        wait_drain("multi_drain");
        enable_i = 1'b0;
        wait_idle("multi_idle");
        chk("multi_cnt", 73'(multi_cnt_o), 73'd2);
        chk("multi_single_cnt", 73'(single_cnt_o), 73'd1);
        chk("multi_wrap", 73'(wrap_cnt), 73'd2);

        // Host write to the word under repair cancels the pending write-back.
        err_s = 4'b1000; err_m = 4'b0000;
        push_m(32'hC, 1'b1, 4'hF, 32'h0);
        push_m(32'hC, 1'b0, 4'h3, 32'h1234_5678);
        rsp_q.push_back(32'h0);
        enable_i = 1'b1;
        i = 0;
        @(negedge clk);
        while (!(mem_bus.req && mem_bus.wen && mem_bus.add == 32'hC) && i < 200) begin
            @(negedge clk); i++;
        end
        chk("hazard_rd_seen", 73'(i < 200), 73'd1);
        step();
        step();
        host_bus.req = 1'b1; host_bus.add = 32'hC; host_bus.wen = 1'b0;
        host_bus.be = 4'h3; host_bus.data = 32'h1234_5678;
        #1;
        chk("hazard_host_gnt", 73'(host_bus.gnt), 73'd1);
        step();
        host_bus.req = 1'b0; host_bus.wen = 1'b1; host_bus.be = 4'h0; host_bus.data = 32'h0;
        enable_i = 1'b0;
        wait_idle("hazard_idle");
        repeat (3) step();
        chk("hazard_drain", 73'(exp_q.size()), 73'd0);
        chk("hazard_single_cnt", 73'(single_cnt_o), 73'd2);
        chk("hazard_wrap", 73'(wrap_cnt), 73'd3);

        // Plain host read while the scrubber is idle.
        push_m(32'h100, 1'b1, 4'hF, 32'h0);
        rsp_q.push_back(32'hA500_0100);
        host_bus.req = 1'b1; host_bus.add = 32'h100; host_bus.be = 4'hF;
        #1;
        chk("host_rd_gnt", 73'(host_bus.gnt), 73'd1);
        step();
        host_bus.req = 1'b0; host_bus.be = 4'h0;
        repeat (3) step();
        chk("host_rsp_drain", 73'(rsp_q.size()), 73'd0);

        // Host holds the port for 200 cycles.
        free_mode = 1'b1; free_scrub = 0;
        host_bus.req = 1'b1; host_bus.add = 32'h200; host_bus.wen = 1'b1; host_bus.be = 4'hF;
        enable_i = 1'b1;
        repeat (200) step();
        snap = free_scrub;
        host_bus.req = 1'b0; host_bus.be = 4'h0;
        enable_i = 1'b0;
        wait_idle("starve_idle");
`ifdef HCI_ECC_SCRUB_STARVE_EN
        chk("starve_forced", 73'(snap > 0), 73'd1);
`else
        chk("starve_blocked", 73'(snap), 73'd0);
`endif

        // Saturation of the 2-bit single-error counter.
        err_s = 4'b1111; free_wb = 0;
        enable_i = 1'b1;
        i = 0;
        while (free_wb < 3 && i < 300) begin step(); i++; end
        enable_i = 1'b0;
        wait_idle("sat_idle");
        chk("sat_wb_seen", 73'(free_wb >= 3), 73'd1);
        chk("sat_single_cnt", 73'(single_cnt_o), 73'd3);
        chk("sat_multi_cnt", 73'(multi_cnt_o), 73'd2);

        // Reset while a scrub read response is outstanding.
        err_s = 4'b0000;
        enable_i = 1'b1;
        i = 0;
        @(negedge clk);
        while (!(mem_bus.req && mem_bus.wen) && i < 200) begin @(negedge clk); i++; end
        chk("rst_rd_seen", 73'(i < 200), 73'd1);
        step();
        rst_i = 1'b1; enable_i = 1'b0;
        step();
        chk("rst_mid_op", {scrub_busy_o, scrub_wrap_o, single_cnt_o, multi_cnt_o,
                           mem_bus.req, host_bus.gnt, host_bus.r_valid}, 73'd0);
        rst_i = 1'b0;
        free_mode = 1'b0;
        repeat (4) step();
        chk("final_exp_q", 73'(exp_q.size()), 73'd0);
        chk("final_rsp_q", 73'(rsp_q.size()), 73'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
